// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: processes DIGIT bits per cycle over WIDTH/DIGIT cycles,
// with the carry held in a register between digits and a valid/ready handshake on each side.
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]    LAST  = CW'(NDIG - 1);
    localparam logic [WIDTH-1:0] DMASK = {WIDTH{1'b1}} >> (WIDTH - DIGIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry;
    logic [CW-1:0]     cnt;

    int                offset;
    logic [DIGIT-1:0]  da;
    logic [DIGIT-1:0]  db;
    logic [DIGIT-1:0]  slice_sum;
    logic              slice_cout;
    logic              c;
    logic [WIDTH-1:0]  sum_next;

    assign in_ready = (state == IDLE);

    // One ripple slice of DIGIT full adders fed by the carry register; the
    // result digit is merged into its place in sum without disturbing the rest.
    always_comb begin
        offset     = int'(cnt) * DIGIT;
        da         = DIGIT'(a_reg >> offset);
        db         = DIGIT'(b_reg >> offset);
        c          = carry;
        slice_sum  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            slice_sum[i] = da[i] ^ db[i] ^ c;
            c            = (da[i] & db[i]) | (c & (da[i] ^ db[i]));
        end
        slice_cout = c;
        sum_next   = (sum & ~(DMASK << offset)) | (WIDTH'(slice_sum) << offset);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    sum   <= sum_next;
                    carry <= slice_cout;
                    // The last digit carries the MSB, so overflow uses the fresh slice result.
                    if (cnt == LAST) begin
                        cout      <= slice_cout;
                        ovf       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (slice_sum[DIGIT-1] != a_reg[WIDTH-1]);
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Testbench for digit_serial_adder: directed vectors and corner sequences on a DIGIT=2 unit,
// plus randomized traffic on DIGIT=1/2/8 units checked against an arithmetic model.
module tb_digit_serial_adder;

    localparam int W    = 8;
    localparam int NOPS = 1000;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed    = 0;
    int total     = 0;
    int rand_done = 0;

    logic       rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    digit_serial_adder #(.WIDTH(W), .DIGIT(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference model: plain integer arithmetic, overflow as out-of-range signed result.
    function automatic vec_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mcin, input logic msub);
        vec_t v;
        int   tot;
        int   st;
        v.a = ma; v.b = mb; v.cin = mcin; v.sub = msub;
        if (msub) begin
            tot = int'(ma) + (255 - int'(mb)) + (1 - int'(mcin));
            st  = int'($signed(ma)) - int'($signed(mb)) - int'(mcin);
        end else begin
            tot = int'(ma) + int'(mb) + int'(mcin);
            st  = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
        end
        v.sum  = tot[7:0];
        v.cout = tot[8];
        v.ovf  = (st > 127) || (st < -128);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, input string tag, input bit drain);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) checkOutput({tag, " in_ready timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checkOutput({tag, " latency"}, 32'(n), 32'd4);
        checkOutput({tag, " sum"},  32'(sum),  32'(v.sum));
        checkOutput({tag, " cout"}, 32'(cout), 32'(v.cout));
        checkOutput({tag, " ovf"},  32'(ovf),  32'(v.ovf));
        if (drain) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checkOutput({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
            checkOutput({tag, " in_ready back"},  32'(in_ready),  32'd1);
        end
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   n;
        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset sum",       32'(sum),       32'd0);
        checkOutput("reset cout",      32'(cout),      32'd0);
        checkOutput("reset ovf",       32'(ovf),       32'd0);
        checkOutput("reset in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i), 1'b1);

        // Back-pressure in DONE with in_valid high and wiggling operands.
        v = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
        applyStimulus(v, "hold", 1'b0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            checkOutput($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("hold%0d in_ready", k),  32'(in_ready),  32'd0);
            checkOutput($sformatf("hold%0d sum", k),       32'(sum),       32'h46);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("hold release out_valid", 32'(out_valid), 32'd0);
        checkOutput("hold release in_ready",  32'(in_ready),  32'd1);
        checkOutput("hold release sum kept",  32'(sum),       32'h46);
        @(posedge clk); #1;
        checkOutput("hold no accept", 32'(in_ready), 32'd1);

        // Reset during the second BUSY cycle aborts the op.
        in_valid = 1'b1; a = 8'h55; b = 8'h11; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort sum",       32'(sum),       32'd0);
        checkOutput("abort in_ready",  32'(in_ready),  32'd1);
        checkOutput("abort cout",      32'(cout),      32'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("abort no result", 32'(out_valid), 32'd0);
        v = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
        applyStimulus(v, "after abort", 1'b1);

        n = 0;
        while (rand_done < 3 && n < 100000) begin
            @(posedge clk); n++;
        end
        if (rand_done < 3) checkOutput("random streams finished", 32'(rand_done), 32'd3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int D  = (gi == 0) ? 1 : (gi == 1) ? 2 : 8;
        localparam int ND = W / D;

        logic       r_rst, r_in_valid, r_in_ready, r_cin, r_sub, r_out_valid, r_out_ready, r_cout, r_ovf;
        logic [7:0] r_a, r_b, r_sum;

        digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk(clk), .rst(r_rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
            .a(r_a), .b(r_b), .cin(r_cin), .sub(r_sub),
            .out_valid(r_out_valid), .out_ready(r_out_ready),
            .sum(r_sum), .cout(r_cout), .ovf(r_ovf)
        );

        initial begin
            vec_t       q[$];
            vec_t       pend;
            int         cyc = 0;
            int         acc_cyc = 0;
            int         accepted = 0;
            int         completed = 0;
            logic       p_iv, p_ir, p_ov, p_or;
            logic [7:0] p_sum;
            string      nm;
            nm = $sformatf("rand D=%0d", D);
            r_rst = 1'b1; r_in_valid = 1'b0; r_out_ready = 1'b0;
            r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            r_rst = 1'b0;
            while (completed < NOPS && cyc < 60000) begin
                p_iv = r_in_valid; p_ir = r_in_ready; p_ov = r_out_valid; p_or = r_out_ready; p_sum = r_sum;
                pend = model(r_a, r_b, r_cin, r_sub);
                @(posedge clk); #1;
                cyc++;
                if (p_iv && p_ir) begin
                    q.push_back(pend);
                    acc_cyc = cyc;
                    accepted++;
                end
                if (p_ov && !p_or) begin
                    checkOutput({nm, " held valid"}, 32'(r_out_valid), 32'd1);
                    checkOutput({nm, " held sum"},   32'(r_sum),       32'(p_sum));
                end
                if (!p_ov && r_out_valid) begin
                    checkOutput({nm, " latency"}, 32'(cyc - acc_cyc), 32'(ND));
                    if (q.size() == 0) begin
                        checkOutput({nm, " unexpected result"}, 32'(q.size()), 32'd1);
                    end else begin
                        checkOutput({nm, " sum"},  32'(r_sum),  32'(q[0].sum));
                        checkOutput({nm, " cout"}, 32'(r_cout), 32'(q[0].cout));
                        checkOutput({nm, " ovf"},  32'(r_ovf),  32'(q[0].ovf));
                    end
                end
                if (p_ov && p_or) begin
                    if (q.size() > 0) void'(q.pop_front());
                    completed++;
                    checkOutput({nm, " out_valid drop"}, 32'(r_out_valid), 32'd0);
                end
                r_in_valid  = (accepted < NOPS) && ($urandom_range(0, 1) == 1);
                r_a         = 8'($urandom);
                r_b         = 8'($urandom);
                r_cin       = 1'($urandom);
                r_sub       = 1'($urandom);
                r_out_ready = ($urandom_range(0, 2) != 0);
            end
            if (completed < NOPS) checkOutput({nm, " completed ops"}, 32'(completed), 32'(NOPS));
            r_in_valid = 1'b0;
            rand_done++;
        end
    end

endmodule
